// File: rtl/relm_adc_io.sv
// relm_adc_io: serial engine for an 8-channel 12-bit SPI ADC (ADC128S022 class).
// A push on cmd_d starts one 16-SCLK frame addressed to the given channel.
// The sample clocked out during a frame belongs to the channel addressed by
// the previous frame, so every result is tagged with that earlier channel.
// Results are popped through res_d/res_q using the relm WD+1-bit word format.
//
// Optional build macro ADC_AVG_EN: cmd_d[5:4]=n averages 2^n samples of one
// channel. The block runs 2^n+1 frames, discards the first frame's data and
// returns the truncated mean, tagged with the requested channel.
//
// Handshake: a push (cmd_d[WD]=1) is taken only in a cycle where cmd_retry=0.
// cmd_retry is registered and equals (state != IDLE). A pop (res_d[WD]=1)
// consumes the result shown on res_q. res_q[WD]=1 means no result is waiting.
// If a frame completes in the same cycle as a pop, the frame completion wins.
//
// The FSM state is held in the signal 'state' of enum type state_t.
`timescale 1ns/1ps

module relm_adc_io #(
    parameter int WD  = 32,
    parameter int DIV = 8
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic [WD:0]   cmd_d,
    output logic          cmd_retry,
    input  logic [WD:0]   res_d,
    output logic [WD:0]   res_q,
    output logic          adc_cs_n_out,
    output logic          adc_saddr_out,
    input  logic          adc_sdat_in,
    output logic          adc_sclk_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Last count value of one SETUP, low, high or HOLD interval.
    localparam logic [7:0] CNT_LAST = 8'(DIV - 1);

    state_t      state;
    state_t      state_nxt;

    // Interval timing and the bit position inside the frame.
    logic [7:0]  cnt;
    logic        phase;        // 0 = SCLK low half, 1 = SCLK high half
    logic        phase_nxt;
    logic [3:0]  bit_idx;
    logic [3:0]  bit_nxt;

    // Next values of the registered pins.
    logic        cs_n_nxt;
    logic        sclk_nxt;
    logic        saddr_nxt;
    logic        retry_nxt;

    // Datapath.
    logic [2:0]  ch;           // channel addressed by the current frame
    logic [2:0]  prev_ch;      // channel addressed by the previous frame
    logic [2:0]  tag;
    logic [2:0]  tag_nxt;
    logic [11:0] shift;
    logic [11:0] result;
    logic [11:0] result_nxt;
    logic        valid;
    logic        overrun;
    logic        sync1;
    logic        sync2;

    // Decoded events.
    logic        push;
    logic        pop;
    logic        accept;
    logic        cnt_last;
    logic        sample;
    logic        frame_done;
    logic        more_frames;

    // Command bits that carry no meaning for this block.
    logic        unused_bits;

    assign push       = cmd_d[WD];
    assign pop        = res_d[WD];
    assign accept     = (state == IDLE) && push;
    assign cnt_last   = (cnt == CNT_LAST);
    assign sample     = (state == SHIFT) && phase && cnt_last;
    assign frame_done = (state == HOLD) && cnt_last;
    assign unused_bits = ^{cmd_d[WD-1:3], res_d[WD-1:0]};

`ifdef ADC_AVG_EN
    logic [1:0]  n_sel;        // log2 of the number of averaged samples
    logic [3:0]  frames_left;  // frames still to run after the current one
    logic        first;        // current frame is the discarded priming frame
    logic [14:0] acc;
    logic [14:0] sum;

    assign more_frames = (frames_left != 4'd0);
    assign sum         = acc + {3'b000, shift};

    // Averaging bookkeeping: frame budget and sample accumulator.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            n_sel       <= 2'd0;
            frames_left <= 4'd0;
            first       <= 1'b0;
            acc         <= 15'd0;
        end else if (accept) begin
            n_sel       <= cmd_d[5:4];
            frames_left <= (cmd_d[5:4] == 2'd0) ? 4'd0 : (4'd1 << cmd_d[5:4]);
            first       <= 1'b1;
            acc         <= 15'd0;
        end else if (frame_done && more_frames) begin
            frames_left <= frames_left - 4'd1;
            first       <= 1'b0;
            if (!first) begin
                acc <= sum;
            end
        end
    end

    // Final result: the plain sample, or the truncated mean when averaging.
    always_comb begin
        result_nxt = shift;
        tag_nxt    = prev_ch;
        if (n_sel != 2'd0) begin
            result_nxt = 12'(sum >> n_sel);
            tag_nxt    = ch;
        end
    end
`else
    assign more_frames = 1'b0;

    // Final result: the sample returned during this frame, tagged with the
    // channel that was addressed one frame earlier.
    always_comb begin
        result_nxt = shift;
        tag_nxt    = prev_ch;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> SETUP -> SHIFT (16 bits) -> HOLD -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (push) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (cnt_last) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (sample && (bit_idx == 4'd15)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (cnt_last) begin
                    state_nxt = more_frames ? SETUP : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Half-period sequencing: toggle the phase every DIV cycles and advance the
    // bit index after each high half.
    always_comb begin
        phase_nxt = phase;
        bit_nxt   = bit_idx;
        if (state == SETUP) begin
            phase_nxt = 1'b0;
            bit_nxt   = 4'd0;
        end else if ((state == SHIFT) && cnt_last) begin
            phase_nxt = ~phase;
            if (phase) begin
                bit_nxt = bit_idx + 4'd1;
            end
        end
    end

    // Output logic: next pin values decoded from the next state. The address
    // bit changes only when a new bit index begins, which is the start of
    // the low half.
    always_comb begin
        cs_n_nxt  = !((state_nxt == SETUP) || (state_nxt == SHIFT));
        sclk_nxt  = (state_nxt == SHIFT) ? phase_nxt : 1'b1;
        retry_nxt = (state_nxt != IDLE);
        saddr_nxt = 1'b0;
        if (state_nxt == SHIFT) begin
            case (bit_nxt)
                4'd2:    saddr_nxt = ch[2];
                4'd3:    saddr_nxt = ch[1];
                4'd4:    saddr_nxt = ch[0];
                default: saddr_nxt = 1'b0;
            endcase
        end
    end

    // Registered pins and the busy flag.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            adc_cs_n_out  <= 1'b1;
            adc_sclk_out  <= 1'b1;
            adc_saddr_out <= 1'b0;
            cmd_retry     <= 1'b0;
        end else begin
            adc_cs_n_out  <= cs_n_nxt;
            adc_sclk_out  <= sclk_nxt;
            adc_saddr_out <= saddr_nxt;
            cmd_retry     <= retry_nxt;
        end
    end

    // Interval counter and phase/bit registers.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            cnt     <= 8'd0;
            phase   <= 1'b0;
            bit_idx <= 4'd0;
        end else begin
            cnt     <= ((state == IDLE) || cnt_last) ? 8'd0 : cnt + 8'd1;
            phase   <= phase_nxt;
            bit_idx <= bit_nxt;
        end
    end

    // Two-flop synchronizer for the asynchronous ADC data line.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= adc_sdat_in;
            sync2 <= sync1;
        end
    end

    // Datapath: latch the channel, shift data in MSB first, publish the
    // result and track valid/overrun.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            ch      <= 3'd0;
            prev_ch <= 3'd0;
            tag     <= 3'd0;
            shift   <= 12'd0;
            result  <= 12'd0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                ch <= cmd_d[2:0];
            end
            if (sample) begin
                shift <= {shift[10:0], sync2};
            end
            if (frame_done && !more_frames) begin
                result  <= result_nxt;
                tag     <= tag_nxt;
                prev_ch <= ch;
                valid   <= 1'b1;
                overrun <= valid && !pop;
            end else if (pop) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

    // Result word, driven straight from registers.
    always_comb begin
        res_q        = '0;
        res_q[WD]    = ~valid;
        res_q[15]    = overrun;
        res_q[14:12] = tag;
        res_q[11:0]  = result;
    end

endmodule

// File: doc/relm_adc_io.md
Name: relm_adc_io

Overview:
- Hardware serial engine for the on-board 8-channel 12-bit SPI ADC (ADC128S022-class: 16 SCLK per frame, address on DIN, data on DOUT).
- Replaces software bit-banging of the ADC pins by the relm core.
- Sits between one relm push port (conversion command), one relm pop port (conversion result) and the four ADC pins.
- Uses the same WD+1-bit push/pop word format as every other relm peripheral.

Parameters:
- WD, 32: relm data width; bus words are WD+1 bits, bit WD is the strobe/flag.
- DIV, 8: clk cycles per SCLK half-period; legal range 3..255. Default gives 3.125 MHz SCLK at 50 MHz.

Ports:
- clk  in  1  system clock
- rst_in  in  1  synchronous reset, active high
- cmd_d  in  WD+1  push word. Bit WD = push strobe; [2:0] = channel; [5:4] = average select (ADC_AVG_EN only); other bits ignored.
- cmd_retry  out  1  push not accepted this cycle
- res_d  in  WD+1  pop word; bit WD = pop strobe; other bits ignored
- res_q  out  WD+1  result word: [WD] = ~valid, [15] = overrun, [14:12] = data channel, [11:0] = sample, all other bits 0
- adc_cs_n_out  out  1  ADC chip select, active low
- adc_saddr_out  out  1  ADC DIN
- adc_sdat_in  in  1  ADC DOUT, asynchronous
- adc_sclk_out  out  1  ADC SCLK, idle high

Behaviour:
- Reset state:
  - adc_cs_n_out=1, adc_sclk_out=1, adc_saddr_out=0.
  - State IDLE, valid=0, overrun=0, result=0, prev_ch=0.
  - cmd_retry=0 in the cycle after reset is released.
- Reset mid-frame:
  - Immediately forces all of the above; the frame is abandoned.
  - The first result after such a reset carries tag ch0 and is unqualified.
- adc_sdat_in passes through a 2-flop synchronizer that runs continuously and is reset to 0.
- cmd_retry = (state != IDLE), registered.
  - A push with cmd_d[WD]=1 while cmd_retry=1 is ignored; relm repeats it.
  - Acceptance at cycle 0 latches ch=cmd_d[2:0].
- States IDLE -> SETUP -> SHIFT -> HOLD -> IDLE:
  - SETUP: cs_n=0 from cycle 1, held for DIV cycles with sclk=1.
  - SHIFT, for bit k=0..15:
    - Low phase: sclk=0 for DIV cycles; saddr updated at the start of the low phase.
    - High phase: sclk=1 for DIV cycles; synchronized sdat sampled on the last clk of the high phase, shifted in MSB first.
    - saddr = ch[2], ch[1], ch[0] for k = 2, 3, 4; 0 for all other k.
  - HOLD: after bit 15, sclk stays 1 and cs_n=1 for DIV cycles.
  - HOLD end:
    - result[11:0] = shift[11:0] (bits k=4..15).
    - tag = prev_ch; then prev_ch := ch.
    - valid := 1; state IDLE.
- Latency: valid and ~cmd_retry appear exactly 34*DIV+1 cycles after the accept cycle.
- Pipeline semantics: each frame returns the channel addressed by the previous frame; the tag always names the channel the data belongs to.
- Pop:
  - res_q is driven from registers; res_q[WD] = ~valid.
  - res_d[WD]=1 clears valid and overrun on the next edge.
  - Popping while valid=0 has no effect; res_q[WD]=1 tells software to retry.
- Completion with valid still 1: result is overwritten, overrun := 1.
- Pop and completion in the same cycle: completion wins; valid stays 1, overrun=0.

Optional Feature:
- Macro: ADC_AVG_EN.
- When defined:
  - cmd_d[5:4]=n selects 2^n samples of channel ch.
  - For n>0 the block runs 2^n+1 back-to-back frames, all addressed to ch; frames are separated only by HOLD.
  - The first frame's data is discarded; the remaining 2^n samples are summed in a 15-bit accumulator.
  - result[11:0] = sum >> n, truncated; tag = ch; total latency (2^n+1)*(34*DIV)+1.
  - n=0 behaves exactly like the undefined case.
- When undefined: bits [5:4] are ignored, the accumulator is absent, every command is one frame.

Test Plan (DIV=4 unless noted):
- Reset, no command -> cs_n=1, sclk=1, saddr=0, res_q[WD]=1, cmd_retry=0 held for 200 cycles.
- Push ch=5; ADC model returns 0xABC -> SCLK high phases last 4 cycles; saddr pattern 0,0,1,0,1 then 0s. valid at cycle 137. res_q[15:0]=0x0ABC (tag 0); second push ch=2 -> tag 5.
- Second push issued while busy -> cmd_retry=1 and the push is ignored; a push re-issued in the first cycle cmd_retry=0 is accepted, with exactly one frame per accepted push.
- No pop between two frames -> res_q[15]=1 after the second frame. Pop strobe in the completion cycle -> valid=1, overrun=0.
- Assert rst_in at SHIFT bit 7 -> next edge cs_n=1, sclk=1, valid=0; a new push afterwards produces a full 16-clock frame.
- ADC_AVG_EN, n=2, ch=3, model returns 100, 200, 300, 400, 500 -> 5 frames; result=(200+300+400+500)>>2=350, tag 3, valid at cycle 5*136+1=681.
